// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM port arbiter.
// Covers the state encoding, owner tags, response tag and burst counter helper.
package ram_arb_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;

  // Saturating increment: an uncontended owner parks at max instead of wrapping.
  function automatic logic [CNT_W-1:0] burst_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] max_cnt);
    return (cnt >= max_cnt) ? max_cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Request/response port of one RAM client: valid/ready request channel plus
// a fixed-latency read-response pulse.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
);
  logic              valid;
  logic              ready;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, wr, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, wr, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram_rsp_pipe.sv
// Two-deep {valid, owner} shift register that tracks each issued read until
// the RAM's registered output holds its data.
module ram_rsp_pipe
  import ram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage1_q, stage1_d;
  rsp_tag_t stage2_q, stage2_d;

  always_comb begin
    stage1_d = tag_in;
    stage2_d = stage1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  assign tag_out = stage2_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// with bounded bursts, registered RAM controls and tagged read returns.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  a_if,
  ram_port_arbiter_if.slave  b_if,
  output logic               ram_cs,
  output logic               ram_wr,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  input  logic [DATA_W-1:0]  ram_dout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;

  logic              acc_a, acc_b, accept;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rsp_tag_t          rsp_in, rsp_out;

  // Ready comes straight from the state register, so valid never reaches ready combinationally.
  assign a_if.ready = (state_q == OWN_A);
  assign b_if.ready = (state_q == OWN_B);

  assign acc_a     = a_if.valid && (state_q == OWN_A);
  assign acc_b     = b_if.valid && (state_q == OWN_B);
  assign accept    = acc_a || acc_b;
  assign sel_wr    = acc_b ? b_if.wr    : a_if.wr;
  assign sel_addr  = acc_b ? b_if.addr  : a_if.addr;
  assign sel_wdata = acc_b ? b_if.wdata : a_if.wdata;
  assign cnt_inc   = burst_inc(burst_cnt_q, MAX_CNT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (a_if.valid && b_if.valid) state_d = (last_q == OWNER_A) ? OWN_B : OWN_A;
        else if (a_if.valid)          state_d = OWN_A;
        else if (b_if.valid)          state_d = OWN_B;
      end
      OWN_A: begin
        if (a_if.valid) begin
          last_d      = OWNER_A;
          burst_cnt_d = cnt_inc;
        end
        if (b_if.valid && (!a_if.valid || cnt_inc == MAX_CNT)) state_d = OWN_B;
        else if (!a_if.valid && !b_if.valid)                 state_d = IDLE;
      end
      OWN_B: begin
        if (b_if.valid) begin
          last_d      = OWNER_B;
          burst_cnt_d = cnt_inc;
        end
        if (a_if.valid && (!b_if.valid || cnt_inc == MAX_CNT)) state_d = OWN_A;
        else if (!a_if.valid && !b_if.valid)                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Each new owner starts with a fresh burst allowance.
    if (state_d != state_q) burst_cnt_d = '0;
  end

  always_comb begin
    ram_cs_d   = accept;
    ram_wr_d   = accept && sel_wr;
    ram_addr_d = accept ? sel_addr  : ram_addr_q;
    ram_din_d  = accept ? sel_wdata : ram_din_q;
    rsp_in     = '{valid: accept && !sel_wr, owner: acc_b ? OWNER_B : OWNER_A};
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= OWNER_B;
      burst_cnt_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      ram_cs_q    <= ram_cs_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
    end
  end

  assign ram_cs   = ram_cs_q;
  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

  ram_rsp_pipe u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (rsp_in),
    .tag_out (rsp_out)
  );

  // The tag emerges exactly when the RAM's registered output holds that read's data.
  assign a_if.rvalid = rsp_out.valid && (rsp_out.owner == OWNER_A);
  assign b_if.rvalid = rsp_out.valid && (rsp_out.owner == OWNER_B);
  assign a_if.rdata  = a_if.rvalid ? ram_dout : '0;
  assign b_if.rdata  = b_if.rvalid ? ram_dout : '0;

endmodule
